// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb sequencer: state encoding,
// fire-arm bit indices, coordinate width and the blast-set membership test.
package bomb_pkg;

   localparam int COORD_W = 5;
   localparam logic [COORD_W-1:0] GRID_MAX_DEF = 5'd18;

   localparam int DIR_N = 0;
   localparam int DIR_S = 1;
   localparam int DIR_E = 2;
   localparam int DIR_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_BOOM  = 2'd2,
      ST_CLEAR = 2'd3
   } bomb_state_e;

   // Arms are already masked at the grid edges, so the +/-1 never wraps into play.
   function automatic logic in_blast(
      input logic [COORD_W-1:0] bx,
      input logic [COORD_W-1:0] by,
      input logic [3:0]         fire,
      input logic [COORD_W-1:0] px,
      input logic [COORD_W-1:0] py
   );
      logic same_col;
      logic same_row;
      same_col = (px == bx);
      same_row = (py == by);
      return (same_col && same_row)
          || (fire[DIR_N] && same_col && (py == by - 1'b1))
          || (fire[DIR_S] && same_col && (py == by + 1'b1))
          || (fire[DIR_E] && same_row && (px == bx + 1'b1))
          || (fire[DIR_W] && same_row && (px == bx - 1'b1));
   endfunction

endpackage

// File: rtl/game_tick_prescaler.sv
// Free-running game-tick prescaler: one-cycle tick every TICK_DIV clocks.
// Shared with the monster movement logic, so it is never restarted locally.
module game_tick_prescaler #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic RSTN,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/bomb_fuse_ctrl.sv
// Bomb lifecycle sequencer: place -> fuse countdown -> explosion -> clear.
// Optional remote detonation input is built in when BOMB_REMOTE_EN is defined.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | no bomb; valid place_we arms at the latched cell
//  ST_ARMED | bomb shown, fuse counts down on game ticks
//  ST_BOOM  | explosion shown, fire arms held, hits flagged once each
//  ST_CLEAR | single cycle that wipes the bomb and hit flags
module bomb_fuse_ctrl
   import bomb_pkg::*;
#(
   parameter int                     TICK_DIV   = 25_000_000,
   parameter int                     FUSE_TICKS = 3,
   parameter int                     FIRE_TICKS = 2,
   parameter logic [COORD_W-1:0]     GRID_MAX   = GRID_MAX_DEF
) (
   input  logic               clk,
   input  logic               RSTN,
   input  logic               place_we,
   input  logic [COORD_W-1:0] place_x,
   input  logic [COORD_W-1:0] place_y,
   input  logic [3:0]         wall,
   input  logic [COORD_W-1:0] Man_x,
   input  logic [COORD_W-1:0] Man_y,
   input  logic [COORD_W-1:0] Monster_x,
   input  logic [COORD_W-1:0] Monster_y,
   input  logic               Monster_alive,
`ifdef BOMB_REMOTE_EN
   input  logic               detonate,
`endif
   output logic               Bomb_EN,
   output logic [COORD_W-1:0] Bomb_x,
   output logic [COORD_W-1:0] Bomb_y,
   output logic               Boom,
   output logic [3:0]         Fire,
   output logic               man_hit,
   output logic               monster_hit,
   output logic               place_rej,
   output logic [4:0]         status
);

   logic tick;
   logic det;

   game_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .RSTN (RSTN),
      .tick (tick)
   );

`ifdef BOMB_REMOTE_EN
   assign det = detonate;
`else
   assign det = 1'b0;
`endif

   bomb_state_e        state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [COORD_W-1:0] bomb_x_q, bomb_x_d;
   logic [COORD_W-1:0] bomb_y_q, bomb_y_d;
   logic               bomb_en_q, bomb_en_d;
   logic               boom_q, boom_d;
   logic [3:0]         fire_q, fire_d;
   logic               man_flag_q, man_flag_d;
   logic               mon_flag_q, mon_flag_d;
   logic               man_hit_q, man_hit_d;
   logic               mon_hit_q, mon_hit_d;
   logic               place_rej_q, place_rej_d;
   logic [4:0]         status_q, status_d;

   logic [3:0] fire_entry;
   logic       man_in;
   logic       mon_in;
   logic       last_tick;

   // Walls and grid edges both stop an arm; there is no wrap-around.
   always_comb begin
      fire_entry = ~wall;
      if (bomb_x_q == '0)       fire_entry[DIR_W] = 1'b0;
      if (bomb_x_q == GRID_MAX) fire_entry[DIR_E] = 1'b0;
      if (bomb_y_q == '0)       fire_entry[DIR_N] = 1'b0;
      if (bomb_y_q == GRID_MAX) fire_entry[DIR_S] = 1'b0;
   end

   assign man_in    = in_blast(bomb_x_q, bomb_y_q, fire_q, Man_x, Man_y);
   assign mon_in    = Monster_alive && in_blast(bomb_x_q, bomb_y_q, fire_q, Monster_x, Monster_y);
   assign last_tick = tick && (cnt_q == 4'd1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bomb_x_d    = bomb_x_q;
      bomb_y_d    = bomb_y_q;
      bomb_en_d   = bomb_en_q;
      boom_d      = boom_q;
      fire_d      = fire_q;
      man_flag_d  = man_flag_q;
      mon_flag_d  = mon_flag_q;
      man_hit_d   = 1'b0;
      mon_hit_d   = 1'b0;
      place_rej_d = 1'b0;
      status_d    = {state_q, cnt_q[2:0]};

      case (state_q)
         ST_IDLE: begin
            if (place_we) begin
               if ((place_x <= GRID_MAX) && (place_y <= GRID_MAX)) begin
                  state_d   = ST_ARMED;
                  cnt_d     = 4'(FUSE_TICKS);
                  bomb_x_d  = place_x;
                  bomb_y_d  = place_y;
                  bomb_en_d = 1'b1;
               end else begin
                  place_rej_d = 1'b1;
               end
            end
         end
         ST_ARMED: begin
            place_rej_d = place_we;
            if (det || last_tick) begin
               state_d = ST_BOOM;
               cnt_d   = 4'(FIRE_TICKS);
               boom_d  = 1'b1;
               fire_d  = fire_entry;
            end else if (tick) begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_BOOM: begin
            place_rej_d = place_we;
            if (man_in && !man_flag_q) begin
               man_hit_d  = 1'b1;
               man_flag_d = 1'b1;
            end
            if (mon_in && !mon_flag_q) begin
               mon_hit_d  = 1'b1;
               mon_flag_d = 1'b1;
            end
            if (last_tick) begin
               state_d   = ST_CLEAR;
               cnt_d     = 4'd0;
               bomb_en_d = 1'b0;
               boom_d    = 1'b0;
               fire_d    = 4'd0;
               bomb_x_d  = '0;
               bomb_y_d  = '0;
            end else if (tick) begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_CLEAR: begin
            place_rej_d = place_we;
            man_flag_d  = 1'b0;
            mon_flag_d  = 1'b0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         bomb_x_q    <= '0;
         bomb_y_q    <= '0;
         bomb_en_q   <= 1'b0;
         boom_q      <= 1'b0;
         fire_q      <= 4'd0;
         man_flag_q  <= 1'b0;
         mon_flag_q  <= 1'b0;
         man_hit_q   <= 1'b0;
         mon_hit_q   <= 1'b0;
         place_rej_q <= 1'b0;
         status_q    <= 5'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bomb_x_q    <= bomb_x_d;
         bomb_y_q    <= bomb_y_d;
         bomb_en_q   <= bomb_en_d;
         boom_q      <= boom_d;
         fire_q      <= fire_d;
         man_flag_q  <= man_flag_d;
         mon_flag_q  <= mon_flag_d;
         man_hit_q   <= man_hit_d;
         mon_hit_q   <= mon_hit_d;
         place_rej_q <= place_rej_d;
         status_q    <= status_d;
      end
   end

   assign Bomb_EN     = bomb_en_q;
   assign Bomb_x      = bomb_x_q;
   assign Bomb_y      = bomb_y_q;
   assign Boom        = boom_q;
   assign Fire        = fire_q;
   assign man_hit     = man_hit_q;
   assign monster_hit = mon_hit_q;
   assign place_rej   = place_rej_q;
   assign status      = status_q;

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// Bench for bomb_fuse_ctrl: scenarios checked every cycle against a timeline
// model derived from tick arithmetic (tick edges are multiples of TD).
`timescale 1ns/1ps
module tb_bomb_fuse_ctrl;

   localparam int TD   = 4;
   localparam int FUSE = 3;
   localparam int FIRE = 2;
   localparam int GMAX = 18;

   logic       clk = 1'b0;
   logic       RSTN = 1'b0;
   logic       place_we = 1'b0;
   logic [4:0] place_x = '0, place_y = '0;
   logic [3:0] wall = '0;
   logic [4:0] Man_x = '0, Man_y = '0, Monster_x = '0, Monster_y = '0;
   logic       Monster_alive = 1'b0;
   logic       detonate = 1'b0;
   logic       Bomb_EN, Boom, man_hit, monster_hit, place_rej;
   logic [4:0] Bomb_x, Bomb_y, status;
   logic [3:0] Fire;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bomb_fuse_ctrl #(.TICK_DIV(TD), .FUSE_TICKS(FUSE), .FIRE_TICKS(FIRE), .GRID_MAX(5'(GMAX))) dut (
      .clk(clk), .RSTN(RSTN), .place_we(place_we), .place_x(place_x), .place_y(place_y),
      .wall(wall), .Man_x(Man_x), .Man_y(Man_y), .Monster_x(Monster_x), .Monster_y(Monster_y),
      .Monster_alive(Monster_alive),
`ifdef BOMB_REMOTE_EN
      .detonate(detonate),
`endif
      .Bomb_EN(Bomb_EN), .Bomb_x(Bomb_x), .Bomb_y(Bomb_y), .Boom(Boom), .Fire(Fire),
      .man_hit(man_hit), .monster_hit(monster_hit), .place_rej(place_rej), .status(status)
   );

   always #5 clk = ~clk;

   // Clock edges seen since reset release; the prescaler fires on every TD-th one.
   always @(posedge clk or negedge RSTN) begin
      if (!RSTN) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic logic [23:0] observed();
      return {Bomb_EN, Bomb_x, Bomb_y, Boom, Fire, man_hit, monster_hit, place_rej, status};
   endfunction

   function automatic int next_tick(int e);
      return (e / TD + 1) * TD;
   endfunction

   function automatic logic blast(int bx, int by, logic [3:0] f, int px, int py);
      return (px == bx && py == by)
          || (f[0] && px == bx && py == by - 1) || (f[1] && px == bx && py == by + 1)
          || (f[2] && py == by && px == bx + 1) || (f[3] && py == by && px == bx - 1);
   endfunction

   function automatic logic [4:0] state_after(int e, int a, int b, int c);
      if (e < a || e > c) return 5'd0;
      if (e == c)         return {2'd3, 3'd0};
      if (e < b)          return {2'd1, 3'(FUSE - (e / TD - a / TD))};
      return {2'd2, 3'(FIRE - (e / TD - b / TD))};
   endfunction

   // det_mode: 0 none, 1 detonate just after the first fuse tick, 2 detonate on the final fuse tick
   task automatic run_bomb(input int x, input int y, input logic [3:0] w,
                           input int mx, input int my, input int ox, input int oy,
                           input logic alive, input int delay, input int rej_off, input int det_mode);
      int a, b, bf, c, d, r, e;
      logic [3:0] fx;
      logic man_in, mon_in;
      logic [23:0] exp_v;
      @(negedge clk);
      Man_x = 5'(mx); Man_y = 5'(my); Monster_x = 5'(ox); Monster_y = 5'(oy);
      Monster_alive = alive; wall = w;
      a  = cyc + 1 + delay;
      bf = next_tick(a) + TD * (FUSE - 1);
      d  = (det_mode == 1) ? next_tick(a) + 1 : (det_mode == 2) ? bf : -1;
      b  = bf;
`ifdef BOMB_REMOTE_EN
      if (d > 0 && d < bf) b = d;
`endif
      c  = next_tick(b) + TD * (FIRE - 1);
      r  = (rej_off > 0) ? a + rej_off : -1;
      fx = ~w;
      if (x == 0)    fx[3] = 1'b0;
      if (x == GMAX) fx[2] = 1'b0;
      if (y == 0)    fx[0] = 1'b0;
      if (y == GMAX) fx[1] = 1'b0;
      man_in = blast(x, y, fx, int'(Man_x), int'(Man_y));
      mon_in = alive && blast(x, y, fx, int'(Monster_x), int'(Monster_y));
      while (cyc <= c + 2) begin
         e = cyc;
         exp_v = {(e >= a && e < c), (e >= a && e < c) ? 5'(x) : 5'd0, (e >= a && e < c) ? 5'(y) : 5'd0,
                  (e >= b && e < c), (e >= b && e < c) ? fx : 4'd0,
                  man_in && (e == b + 1), mon_in && (e == b + 1), (e == r),
                  state_after(e - 1, a, b, c)};
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL bomb(%0d,%0d) edge %0d: got %h expected %h", x, y, e, observed(), exp_v);
         end
         place_we = (e + 1 == a) || (e + 1 == r);
         place_x  = (e + 1 == r) ? 5'($urandom_range(0, 31)) : 5'(x);
         place_y  = (e + 1 == r) ? 5'($urandom_range(0, 31)) : 5'(y);
         detonate = (e + 1 == d);
         @(negedge clk);
      end
      place_we = 1'b0;
      detonate = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (observed() !== 24'd0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 000000", observed());
      end
   endtask

   task automatic test_basic();
      run_bomb(5, 7, 4'b0000, 15, 15, 12, 3, 1'b1, 0, 0, 0);
      run_bomb(9, 2, 4'b1010, 1, 1, 30, 30, 1'b0, 2, 0, 0);
   endtask

   task automatic test_edge_fire();
      run_bomb(0, 18, 4'b0100, 10, 10, 10, 11, 1'b1, 1, 0, 0);
      run_bomb(18, 0, 4'b0000, 18, 1, 17, 0, 1'b1, 3, 0, 0);
   endtask

   task automatic test_hits();
      run_bomb(5, 7, 4'b0000, 6, 7, 5, 6, 1'b1, 0, 0, 0);
      run_bomb(5, 7, 4'b0000, 6, 7, 5, 6, 1'b0, 1, 0, 0);
      run_bomb(5, 7, 4'b0000, 5, 7, 4, 7, 1'b1, 2, 0, 0);
   endtask

   task automatic test_reject();
      run_bomb(5, 7, 4'b0000, 0, 0, 0, 0, 1'b0, 0, 2, 0);
      @(negedge clk);
      place_we = 1'b1; place_x = 5'd20; place_y = 5'd3;
      @(negedge clk);
      place_we = 1'b0;
      checks++;
      if ({place_rej, Bomb_EN, Bomb_x, Bomb_y, status} !== {1'b1, 1'b0, 15'd0}) begin
         errors++;
         $display("FAIL reject_idle: got rej=%b en=%b x=%0d y=%0d st=%h expected rej=1 rest 0",
                  place_rej, Bomb_EN, Bomb_x, Bomb_y, status);
      end
      @(negedge clk);
      checks++;
      if ({place_rej, Bomb_EN, status} !== 7'd0) begin
         errors++;
         $display("FAIL reject_idle_after: got rej=%b en=%b st=%h expected 0", place_rej, Bomb_EN, status);
      end
   endtask

   task automatic test_random();
      int x, y, mx, my, ox, oy;
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 3))
            0:       x = 0;
            1:       x = GMAX;
            default: x = $urandom_range(0, GMAX);
         endcase
         y  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? GMAX : 0) : $urandom_range(0, GMAX);
         mx = x + $urandom_range(0, 2) - 1; my = y + $urandom_range(0, 2) - 1;
         ox = x + $urandom_range(0, 2) - 1; oy = y + $urandom_range(0, 2) - 1;
         if (mx < 0) mx = 31;
         if (my < 0) my = 31;
         if (ox < 0) ox = 31;
         if (oy < 0) oy = 31;
         run_bomb(x, y, 4'($urandom_range(0, 15)), mx, my, ox, oy, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0, 0);
      end
   endtask

   task automatic test_reset_mid_boom();
      int n;
      @(negedge clk);
      place_we = 1'b1; place_x = 5'd9; place_y = 5'd9; wall = 4'd0;
      @(negedge clk);
      place_we = 1'b0;
      n = 0;
      while (!Boom && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (Boom !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_boom_reach: Boom=%b after %0d cycles, expected 1", Boom, n);
      end
      #2 RSTN = 1'b0;
      #1;
      checks++;
      if (observed() !== 24'd0) begin
         errors++;
         $display("FAIL reset_async: got %h expected 000000", observed());
      end
      @(negedge clk);
      @(negedge clk);
      RSTN = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (observed() !== 24'd0) begin
         errors++;
         $display("FAIL reset_release: got %h expected 000000", observed());
      end
   endtask

`ifdef BOMB_REMOTE_EN
   task automatic test_remote();
      run_bomb(7, 7, 4'b0000, 8, 7, 7, 8, 1'b1, 0, 0, 1);
      run_bomb(3, 4, 4'b0011, 3, 3, 2, 4, 1'b1, 2, 0, 2);
   endtask
`endif

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      RSTN = 1'b1;
      @(negedge clk);
      test_basic();
      test_edge_fire();
      test_hits();
      test_reject();
      test_random();
      test_reset_mid_boom();
`ifdef BOMB_REMOTE_EN
      test_remote();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
